// File: rtl/aes_key_expand_seq.sv
// AES-128 key schedule generator: one round key per clock, presented as a flat
// 1408-bit bus (round 0 first) qualified by sched_valid.

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // FIPS-197 forward S-box, entry x at bits [8*x : 8*x+7]
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TABLE[{in_byte, 3'b000} +: 8];
endmodule

module aes_key_expand_seq #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [0:127]                    key_in,
    input  logic                            key_load,
    output logic                            busy,
    output logic                            sched_valid,
    output logic [0:128*(NUM_ROUNDS+1)-1]   schedule
);
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam int SW = 128 * (NUM_ROUNDS + 1);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   round_q, round_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [0:127]    rk_q, rk_d;
    logic [0:SW-1]   schedule_q, schedule_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;

    logic [31:0]     w0, w1, w2, w3;
    logic [31:0]     rot_word, sub_word, temp_word;
    logic [31:0]     nw0, nw1, nw2, nw3;
    logic [0:127]    next_rk;

    // The previous round key is kept in rk_q so the bus is only ever written
    assign w0 = rk_q[0:31];
    assign w1 = rk_q[32:63];
    assign w2 = rk_q[64:95];
    assign w3 = rk_q[96:127];

    assign rot_word = {w3[23:0], w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .in_byte  (rot_word[31-8*gi -: 8]),
                .out_byte (sub_word[31-8*gi -: 8])
            );
        end
    endgenerate

    assign temp_word = sub_word ^ {rcon_q, 24'h000000};
    assign nw0 = w0 ^ temp_word;
    assign nw1 = w1 ^ nw0;
    assign nw2 = w2 ^ nw1;
    assign nw3 = w3 ^ nw2;
    assign next_rk = {nw0, nw1, nw2, nw3};

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        rk_d       = rk_q;
        schedule_d = schedule_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (key_load) begin
                    schedule_d[0 +: 128] = key_in;
                    rk_d    = key_in;
                    round_d = RW'(1);
                    rcon_d  = 8'h01;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                schedule_d[{round_q, 7'b0000000} +: 128] = next_rk;
                rk_d    = next_rk;
                round_d = round_q + RW'(1);
                rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (round_q == RW'(NUM_ROUNDS)) begin
                    round_d = '0;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            round_q    <= '0;
            rcon_q     <= 8'h01;
            rk_q       <= '0;
            schedule_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
            rk_q       <= rk_d;
            schedule_q <= schedule_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign busy        = busy_q;
    assign sched_valid = valid_q;
    assign schedule    = schedule_q;
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: random and FIPS-197 keys checked against a
// word-level key expansion model whose S-box is derived from GF(2^8) inversion.

module tb_aes_key_expand_seq;
    logic            clk = 1'b0;
    logic            n_rst;
    logic [0:127]    key_in;
    logic            key_load;
    logic            busy;
    logic            sched_valid;
    logic [0:1407]   schedule;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sbox_tab [256];

    localparam logic [0:127] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] FIPS_S1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] FIPS_S10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] SEQ_S1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [0:127] SEQ_S10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .key_in      (key_in),
        .key_load    (key_load),
        .busy        (busy),
        .sched_valid (sched_valid),
        .schedule    (schedule)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse (x^254)
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] expand(input logic [0:127] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1407] res;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) res[32*i +: 32] = w[i];
        return res;
    endfunction

    function automatic logic [0:127] slot(input int r);
        return schedule[128*r +: 128];
    endfunction

    function automatic logic [0:127] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Load a key, follow the 10-cycle busy window, optionally poke a second
    // load at cycle 4, then compare the whole bus against the model
    task automatic run_expansion(input logic [0:127] key, input bit inject,
                                 input logic [0:127] other, input string tag);
        logic [0:1407] exp_sched;
        exp_sched = expand(key);
        key_in   = key;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        key_in   = rand_key();
        n_vec++;
        if (busy !== 1'b1 || sched_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s load_edge: busy=%b valid=%b expected busy=1 valid=0", tag, busy, sched_valid);
        end
        for (int c = 1; c <= 10; c++) begin
            if (inject && c == 4) begin
                key_in   = other;
                key_load = 1'b1;
            end
            @(posedge clk); #1;
            key_load = 1'b0;
            n_vec++;
            if (c < 10) begin
                if (busy !== 1'b1 || sched_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_window c=%0d: busy=%b valid=%b expected busy=1 valid=0",
                             tag, c, busy, sched_valid);
                end
            end else if (busy !== 1'b0 || sched_valid !== 1'b1) begin
                n_err++;
                $display("FAIL %s valid_edge: busy=%b valid=%b expected busy=0 valid=1", tag, busy, sched_valid);
            end
        end
        n_vec++;
        if (schedule !== exp_sched) begin
            n_err++;
            $display("FAIL %s schedule: got %h expected %h", tag, schedule, exp_sched);
        end
        $display("%s: key=%h inject=%0d expanded, slot10=%h", tag, key, inject, slot(10));
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        key_load = 1'b1;
        key_in   = rand_key();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                n_rst    = 1'b1;
                key_load = 1'b0;
            end
            @(posedge clk); #1;
            n_vec++;
            if (schedule !== '0 || busy !== 1'b0 || sched_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset c=%0d: busy=%b valid=%b sched_nonzero=%b expected all zero",
                         c, busy, sched_valid, |schedule);
            end
        end
        $display("reset: held 2 cycles with key_load=1, idle afterwards");
    endtask

    task automatic test_fips();
        run_expansion(FIPS_KEY, 1'b0, '0, "fips");
        n_vec++;
        if (slot(1) !== FIPS_S1) begin
            n_err++;
            $display("FAIL fips slot1: got %h expected %h", slot(1), FIPS_S1);
        end
        n_vec++;
        if (slot(10) !== FIPS_S10) begin
            n_err++;
            $display("FAIL fips slot10: got %h expected %h", slot(10), FIPS_S10);
        end
    endtask

    task automatic test_back_to_back();
        run_expansion(SEQ_KEY, 1'b0, '0, "back_to_back");
        n_vec++;
        if (slot(1) !== SEQ_S1) begin
            n_err++;
            $display("FAIL b2b slot1: got %h expected %h", slot(1), SEQ_S1);
        end
        n_vec++;
        if (slot(10) !== SEQ_S10) begin
            n_err++;
            $display("FAIL b2b slot10: got %h expected %h", slot(10), SEQ_S10);
        end
    endtask

    task automatic test_load_ignored();
        for (int i = 0; i < 2; i++)
            run_expansion(rand_key(), 1'b1, rand_key(), "load_ignored");
    endtask

    task automatic test_reset_mid();
        key_in   = rand_key();
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        n_vec++;
        if (schedule !== '0 || busy !== 1'b0 || sched_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b valid=%b sched_nonzero=%b expected all zero",
                     busy, sched_valid, |schedule);
        end
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || sched_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid idle: busy=%b valid=%b expected 0 0", busy, sched_valid);
        end
        $display("reset_mid: expansion aborted at cycle 5");
        run_expansion(FIPS_KEY, 1'b0, '0, "after_reset");
        n_vec++;
        if (slot(10) !== FIPS_S10) begin
            n_err++;
            $display("FAIL after_reset slot10: got %h expected %h", slot(10), FIPS_S10);
        end
    endtask

    task automatic test_stability(input logic [0:127] last_key);
        logic [0:1407] exp_sched;
        exp_sched = expand(last_key);
        for (int c = 0; c < 20; c++) begin
            key_in = rand_key();
            @(posedge clk); #1;
            n_vec++;
            if (schedule !== exp_sched || sched_valid !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL stability c=%0d: valid=%b busy=%b got %h expected %h",
                         c, sched_valid, busy, schedule, exp_sched);
            end
        end
        $display("stability: 20 cycles of key_in toggling with key_load=0");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_expansion(rand_key(), 1'b0, '0, "random");
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        key_load = 1'b0;
        key_in   = '0;
        build_sbox();
        #1;
        test_reset();
        test_fips();
        test_back_to_back();
        test_load_ignored();
        test_reset_mid();
        test_stability(FIPS_KEY);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
